// File: rtl/coverage_stall_monitor.sv
// coverage_stall_monitor: watches NumCh coverage-sum buses for lack of progress and runs a
// round watchdog; raises a latched interrupt with cause code and per-channel stall flags.
// Optional build macro COV_MON_AUTO_ACK_EN: FIRED self-exits after IrqPulse cycles.
module coverage_stall_monitor #(
  parameter int unsigned NumCh      = 4,
  parameter int unsigned CovW       = 30,
  parameter int unsigned CntW       = 32,
  parameter int unsigned BaseWait   = 1000,
  parameter int unsigned ScaleShift = 19,
  parameter int unsigned WdogLimit  = 50000,
  parameter int unsigned IrqPulse   = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic [NumCh*CovW-1:0] cov_i,
  input  logic [NumCh-1:0]      ch_en_i,
  input  logic [63:0]           tohost_i,
  input  logic                  round_clear_i,
  input  logic                  irq_ack_i,
  output logic                  interrupt_o,
  output logic [1:0]            irq_cause_o,
  output logic [NumCh-1:0]      stall_ch_o,
  output logic [15:0]           fire_count_o
);

  // Wide enough that BaseWait * (shifted cov + 1) can never wrap before saturation.
  localparam int unsigned ProdW = CovW + CntW + 33;
  localparam logic [CntW-1:0] CntMax = '1;

  typedef enum logic [0:0] {StRun, StFired} state_e;

  state_e             state_q, state_d;
  logic [CovW-1:0]    prev_q [NumCh];
  logic [CovW-1:0]    prev_d [NumCh];
  logic [CntW-1:0]    cnt_q  [NumCh];
  logic [CntW-1:0]    cnt_d  [NumCh];
  logic [CntW-1:0]    wdog_q, wdog_d;
  logic               interrupt_q, interrupt_d;
  logic [1:0]         cause_q, cause_d;
  logic [NumCh-1:0]   stall_ch_q, stall_ch_d;
  logic [15:0]        fire_cnt_q, fire_cnt_d;

  logic [CovW-1:0]    cov_ch [NumCh];
  logic [ProdW-1:0]   prod   [NumCh];
  logic [CntW-1:0]    thr    [NumCh];
  logic [NumCh-1:0]   hit;
  logic               stall_cond, wdog_cond, clear, fire, leave, auto_done;

  logic unused_cfg;
  assign unused_cfg = ^{tohost_i[63:1], IrqPulse};

  // Per-channel saturating threshold and threshold-reached flags.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NumCh; i++) begin
      cov_ch[i] = cov_i[i*CovW +: CovW];
      prod[i]   = ProdW'(BaseWait) * (ProdW'(cov_ch[i] >> ScaleShift) + ProdW'(1));
      thr[i]    = (prod[i] > ProdW'(CntMax)) ? CntMax : prod[i][CntW-1:0];
      hit[i]    = ch_en_i[i] && (cnt_q[i] >= thr[i]);
    end
  end

  assign stall_cond = (ch_en_i != '0) && (&(hit | ~ch_en_i));
  assign wdog_cond  = (wdog_q >= CntW'(WdogLimit));
  assign clear      = tohost_i[0] | round_clear_i;

`ifdef COV_MON_AUTO_ACK_EN
  logic [CntW-1:0] pulse_q, pulse_d;

  assign auto_done = (state_q == StFired) && (pulse_q == CntW'(IrqPulse - 1));

  // Pulse length counter, restarted on every fire.
  always_comb begin
    pulse_d = pulse_q;
    if (fire) begin
      pulse_d = '0;
    end else if (state_q == StFired) begin
      pulse_d = pulse_q + CntW'(1);
    end
  end

  // Pulse counter register.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_d;
    end
  end
`else
  assign auto_done = 1'b0;
`endif

  // FSM next state; a clear event blocks a fire in the same cycle.
  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    leave   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (!clear && (stall_cond || wdog_cond)) begin
          state_d = StFired;
          fire    = 1'b1;
        end
      end
      StFired: begin
        if (irq_ack_i || clear || auto_done) begin
          state_d = StRun;
          leave   = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Counter, prev_cov and latched-output next state.
  always_comb begin
    prev_d      = prev_q;
    cnt_d       = cnt_q;
    wdog_d      = wdog_q;
    interrupt_d = interrupt_q;
    cause_d     = cause_q;
    stall_ch_d  = stall_ch_q;
    fire_cnt_d  = fire_cnt_q;
    if (state_q == StRun) begin
      for (int i = 0; i < NumCh; i++) begin
        if (cov_ch[i] != prev_q[i]) begin
          prev_d[i] = cov_ch[i];
          cnt_d[i]  = '0;
        end else if (cnt_q[i] != CntMax) begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
        if (clear) cnt_d[i] = '0;
      end
      if (wdog_q != CntMax) wdog_d = wdog_q + CntW'(1);
      if (clear) wdog_d = '0;
      if (fire) begin
        interrupt_d = 1'b1;
        cause_d     = {wdog_cond, stall_cond};
        stall_ch_d  = hit;
        if (fire_cnt_q != 16'hFFFF) fire_cnt_d = fire_cnt_q + 16'd1;
      end
    end else if (leave) begin
      // irq_cause and stall_ch deliberately keep their last values.
      interrupt_d = 1'b0;
      wdog_d      = '0;
      for (int i = 0; i < NumCh; i++) cnt_d[i] = '0;
    end
  end

  // State registers.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StRun;
      for (int i = 0; i < NumCh; i++) begin
        prev_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      wdog_q      <= '0;
      interrupt_q <= 1'b0;
      cause_q     <= '0;
      stall_ch_q  <= '0;
      fire_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      wdog_q      <= wdog_d;
      interrupt_q <= interrupt_d;
      cause_q     <= cause_d;
      stall_ch_q  <= stall_ch_d;
      fire_cnt_q  <= fire_cnt_d;
    end
  end

  assign interrupt_o  = interrupt_q;
  assign irq_cause_o  = cause_q;
  assign stall_ch_o   = stall_ch_q;
  assign fire_count_o = fire_cnt_q;

endmodule

// File: tb/tb_coverage_stall_monitor.sv
// Bench for coverage_stall_monitor: directed scenarios plus randomized traffic checked
// cycle by cycle against a behavioural model of the stall/watchdog rules.
module tb_coverage_stall_monitor;

  localparam int unsigned NumCh      = 2;
  localparam int unsigned CovW       = 30;
  localparam int unsigned CntW       = 32;
  localparam int unsigned BaseWait   = 10;
  localparam int unsigned ScaleShift = 4;
  localparam int unsigned WdogLimit  = 100;
  localparam int unsigned IrqPulse   = 4;
  localparam longint      CntMaxL    = (longint'(1) << CntW) - 1;

  logic                  clock;
  logic                  reset_n;
  logic [NumCh*CovW-1:0] cov;
  logic [NumCh-1:0]      ch_en;
  logic [63:0]           tohost;
  logic                  round_clear;
  logic                  irq_ack;
  logic                  interrupt;
  logic [1:0]            irq_cause;
  logic [NumCh-1:0]      stall_ch;
  logic [15:0]           fire_count;

  int tests = 0;
  int fails = 0;

  // Model state: cycles without progress per channel, round age, latched outputs.
  longint          m_stale [NumCh];
  longint          m_wdog;
  logic [CovW-1:0] m_prev  [NumCh];
  bit              m_fired;
  logic [1:0]      m_cause;
  logic [NumCh-1:0] m_stall;
  int              m_fc;
  int              m_pulse;

  coverage_stall_monitor #(
    .NumCh      (NumCh),
    .CovW       (CovW),
    .CntW       (CntW),
    .BaseWait   (BaseWait),
    .ScaleShift (ScaleShift),
    .WdogLimit  (WdogLimit),
    .IrqPulse   (IrqPulse)
  ) u_dut (
    .clock_i       (clock),
    .reset_ni      (reset_n),
    .cov_i         (cov),
    .ch_en_i       (ch_en),
    .tohost_i      (tohost),
    .round_clear_i (round_clear),
    .irq_ack_i     (irq_ack),
    .interrupt_o   (interrupt),
    .irq_cause_o   (irq_cause),
    .stall_ch_o    (stall_ch),
    .fire_count_o  (fire_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint thr_of(input logic [CovW-1:0] c);
    longint t;
    t = longint'(BaseWait) * (longint'(c >> ScaleShift) + 1);
    if (t > CntMaxL) t = CntMaxL;
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NumCh; i++) begin
      m_stale[i] = 0;
      m_prev[i]  = '0;
    end
    m_wdog  = 0;
    m_fired = 0;
    m_cause = '0;
    m_stall = '0;
    m_fc    = 0;
    m_pulse = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [NumCh-1:0] h;
    logic [CovW-1:0]  c;
    bit st, wd, clr, done;
    clr = tohost[0] || round_clear;
    if (!m_fired) begin
      h = '0;
      for (int i = 0; i < NumCh; i++) begin
        c    = cov[i*CovW +: CovW];
        h[i] = ch_en[i] && (m_stale[i] >= thr_of(c));
      end
      st = (ch_en != '0) && (h == ch_en);
      wd = (m_wdog >= longint'(WdogLimit));
      for (int i = 0; i < NumCh; i++) begin
        c = cov[i*CovW +: CovW];
        if (c != m_prev[i]) begin
          m_prev[i]  = c;
          m_stale[i] = 0;
        end else if (m_stale[i] < CntMaxL) begin
          m_stale[i]++;
        end
        if (clr) m_stale[i] = 0;
      end
      if (m_wdog < CntMaxL) m_wdog++;
      if (clr) m_wdog = 0;
      if (!clr && (st || wd)) begin
        m_fired = 1;
        m_cause = {wd, st};
        m_stall = h;
        if (m_fc < 65535) m_fc++;
        m_pulse = 0;
      end
    end else begin
      done = irq_ack || clr;
`ifdef COV_MON_AUTO_ACK_EN
      if (m_pulse == int'(IrqPulse) - 1) done = 1;
`endif
      if (done) begin
        m_fired = 0;
        m_wdog  = 0;
        for (int i = 0; i < NumCh; i++) m_stale[i] = 0;
      end else begin
        m_pulse++;
      end
    end
  endtask

  // One clock: model step, edge, then compare away from the edge.
  task automatic cycle();
    model_step();
    @(posedge clock);
    @(negedge clock);
    check_val("irq", interrupt, m_fired);
    check_val("cause", irq_cause, m_cause);
    check_val("stall_ch", stall_ch, m_stall);
    check_val("fire_count", fire_count, m_fc);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    #2;
    reset_n     = 1'b0;
    #1;
    check_val("rst_irq", interrupt, 0);
    check_val("rst_fc", fire_count, 0);
    check_val("rst_cause", irq_cause, 0);
    check_val("rst_stall", stall_ch, 0);
    cov         = '0;
    ch_en       = '0;
    tohost      = '0;
    round_clear = 1'b0;
    irq_ack     = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int fire_edge;
    int high_cnt;
    reset_n     = 1'b1;
    cov         = '0;
    ch_en       = '0;
    tohost      = '0;
    round_clear = 1'b0;
    irq_ack     = 1'b0;
    @(negedge clock);
    do_reset();

    // Both channels idle: stall fire on edge 11.
    ch_en = 2'b11;
    repeat (10) cycle();
    check_val("s1_quiet", interrupt, 0);
    cycle();
    check_val("s1_fire", interrupt, 1);
    check_val("s1_cause", irq_cause, 2'b01);
    check_val("s1_stall", stall_ch, 2'b11);
    check_val("s1_fc", fire_count, 1);

    // Ack exit, then a full threshold before refiring.
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    check_val("s5_ack_low", interrupt, 0);
    repeat (10) cycle();
    check_val("s5_no_early", interrupt, 0);
    cycle();
    check_val("s5_refire", interrupt, 1);
    check_val("s5_fc2", fire_count, 2);

    // Reset while FIRED.
    do_reset();

`ifdef COV_MON_AUTO_ACK_EN
    ch_en    = 2'b11;
    repeat (11) cycle();
    high_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (interrupt) high_cnt++;
      cycle();
    end
    check_val("auto_pulse_len", high_cnt, IrqPulse);
    do_reset();
`endif

    // Channel 0 progresses, channel 1 stuck: watchdog fires at edge 101.
    ch_en = 2'b11;
    for (int e = 1; e <= 101; e++) begin
      cov[0 +: CovW] = CovW'(e / 5);
      cycle();
      if (e == 100) check_val("s2_quiet", interrupt, 0);
    end
    check_val("s2_fire", interrupt, 1);
    check_val("s2_cause", irq_cause, 2'b10);
    check_val("s2_stall", stall_ch, 2'b10);
    do_reset();

    // Same, with a tohost clear at edge 99 restarting the round.
    ch_en    = 2'b11;
    high_cnt = 0;
    for (int e = 1; e <= 200; e++) begin
      cov[0 +: CovW] = CovW'(e / 5);
      tohost         = (e == 99) ? 64'h1 : 64'h0;
      cycle();
      if (e <= 150 && interrupt) high_cnt++;
    end
    check_val("s4_quiet", high_cnt, 0);
    check_val("s4_late_fire", interrupt, 1);
    tohost = 64'h1;
    cycle();
    tohost = 64'h0;
    check_val("s4_clear_low", interrupt, 0);
    check_val("s4_fc", fire_count, 1);
    do_reset();

    // No channel enabled: only the watchdog can fire.
    ch_en = 2'b00;
    repeat (100) cycle();
    check_val("s5b_quiet", interrupt, 0);
    cycle();
    check_val("s5b_fire", interrupt, 1);
    check_val("s5b_cause", irq_cause, 2'b10);
    check_val("s5b_stall", stall_ch, 2'b00);
    do_reset();

    // cov = 0x20 raises the threshold to 30; prev_cov starts at 0 so edge 1 is a change.
    ch_en = 2'b11;
    cov   = {CovW'(32'h20), CovW'(32'h20)};
    repeat (11) cycle();
    check_val("s3_not11", interrupt, 0);
    fire_edge = 0;
    for (int e = 12; e <= 40; e++) begin
      cycle();
      if (interrupt && fire_edge == 0) fire_edge = e;
    end
    check_val("s3_fire_edge", fire_edge, 32);
    do_reset();

    // Randomized traffic against the model.
    ch_en = 2'b11;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 49) == 0) ch_en = NumCh'($urandom);
      for (int i = 0; i < NumCh; i++) begin
        if ($urandom_range(0, 39) == 0) begin
          cov[i*CovW +: CovW] = ($urandom_range(0, 9) == 0) ? '1 : CovW'($urandom_range(0, 300));
        end
      end
      tohost      = {$urandom, $urandom};
      tohost[0]   = ($urandom_range(0, 199) == 0);
      round_clear = ($urandom_range(0, 299) == 0);
      irq_ack     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
        ch_en = NumCh'($urandom);
      end else begin
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
